// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry and the
// sequencing states used by the byte-substitution blocks.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_e;

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box, mirror of the forward sbox.
// One byte in, one byte out, no clock.
module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (a)
            8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5;
            8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
            8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e;
            8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
            8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82;
            8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
            8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44;
            8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
            8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32;
            8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
            8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b;
            8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
            8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66;
            8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
            8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49;
            8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
            8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64;
            8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
            8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc;
            8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
            8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50;
            8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
            8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57;
            8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
            8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00;
            8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
            8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05;
            8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
            8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f;
            8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
            8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03;
            8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
            8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41;
            8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
            8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce;
            8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
            8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22;
            8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
            8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8;
            8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
            8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71;
            8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
            8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e;
            8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
            8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b;
            8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
            8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe;
            8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
            8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33;
            8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
            8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59;
            8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
            8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9;
            8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
            8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f;
            8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
            8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d;
            8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
            8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c;
            8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
            8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e;
            8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
            8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63;
            8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/inv_sub_bytes.sv
// Iterative AES InvSubBytes: LANES bytes of the 128-bit state
// are substituted in place per cycle, with a valid/ready wrapper.
module inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    localparam int STEPS = AES_NBYTES / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int LSH   = $clog2(LANES);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    fsm_e                   fsm, fsm_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [AES_STATE_W-1:0] st, st_nxt, st_sub;
    logic [3:0]             base;
    logic [3:0]             pos      [LANES];
    logic [7:0]             lane_in  [LANES];
    logic [7:0]             lane_out [LANES];

    // First byte handled this cycle; LANES is a power of two.
    assign base = 4'(cnt) << LSH;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign pos[j]     = base + 4'(j);
        assign lane_in[j] = st[{pos[j], 3'b000} +: 8];
        inv_sbox u_sbox (
            .a (lane_in[j]),
            .y (lane_out[j])
        );
    end

    always_comb begin
        st_sub = st;
        for (int j = 0; j < LANES; j++) begin
            st_sub[{pos[j], 3'b000} +: 8] = lane_out[j];
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        cnt_nxt = cnt;
        st_nxt  = st;
        case (fsm)
            IDLE: begin
                if (in_valid) begin
                    st_nxt  = in_data;
                    cnt_nxt = '0;
                    fsm_nxt = BUSY;
                end
            end
            BUSY: begin
                st_nxt = st_sub;
                if (cnt == LAST) begin
                    cnt_nxt = '0;
                    fsm_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_nxt = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
            cnt <= '0;
            st  <= '0;
        end else begin
            fsm <= fsm_nxt;
            cnt <= cnt_nxt;
            st  <= st_nxt;
        end
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);
    assign out_data  = st;

endmodule

// File: doc/inv_sub_bytes.md
INV_SUB_BYTES -- requirements
Module: inv_sub_bytes

Interface
REQ-001 Parameter LANES, default 4; number of bytes inverse-substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port in_valid, input, 1, an input block is offered.
REQ-005 Port in_ready, output, 1, the block can accept an input block.
REQ-006 Port in_data, input, 128, AES state; byte i = in_data[8i+7:8i].
REQ-007 Port out_valid, output, 1, out_data holds a completed result.
REQ-008 Port out_ready, input, 1, the consumer accepts the result.
REQ-009 Port out_data, output, 128, InvSubBytes(in_data), using the same byte mapping as in_data.
REQ-010 Port busy, output, 1, high in BUSY and DONE.

Function
REQ-011 The block SHALL implement the FIPS-197 InvSubBytes operation: each output byte = InvSbox(input byte), and InvSbox(Sbox(x)) = x for all 256 values of x.
REQ-012 FSM states SHALL be IDLE, BUSY and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE: on in_valid&&in_ready, the block SHALL load in_data into the 128-bit state register, clear the lane counter cnt, and go to BUSY.
REQ-015 BUSY: each cycle the block SHALL replace bytes cnt*LANES .. cnt*LANES+LANES-1 in place with their InvSbox values, then increment cnt.
REQ-016 BUSY: when cnt = 16/LANES-1, the block SHALL perform the final substitution on that same edge and go to DONE; cnt width = clog2(16/LANES), min 1 bit.
REQ-017 LANES=16 SHALL spend exactly one cycle in BUSY.
REQ-018 Latency: with the accept on edge k, out_valid SHALL rise after edge k+16/LANES (for LANES=4, after edge k+4).
REQ-019 DONE: out_data SHALL remain stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-020 DONE: on out_valid&&out_ready, the block SHALL go to IDLE; in_ready SHALL rise on the following cycle (no same-cycle bypass).
REQ-021 Throughput SHALL be one block per 16/LANES+2 cycles when out_ready is held high.
REQ-022 in_valid and in_data SHALL be ignored outside IDLE; no error or overflow is flagged.
REQ-023 out_data SHALL be driven directly from the state register; no combinational path from in_data to out_data.
REQ-024 The default branch of the lookup SHALL return 8'h00; all 256 entries are explicit.

Reset
REQ-025 On rst_n=0, asynchronously: FSM=IDLE, cnt=0, state register=0 (so out_data=0), out_valid=0, busy=0; in_ready SHALL be 1 once rst_n deasserts.
REQ-026 Reset in BUSY or DONE SHALL discard the block in progress; no partial result is ever presented with out_valid=1.

Structure
REQ-027 Shared package aes_pkg SHALL hold AES_STATE_W=128, AES_NBYTES=16 and the FSM state enum (IDLE/BUSY/DONE).
REQ-028 Sub-module inv_sbox (8-bit combinational InvSbox LUT) SHALL be instantiated LANES times, with lane j addressing byte cnt*LANES+j.
REQ-029 inv_sbox SHALL be the mirror of the existing forward sbox, carry no clock, and add no modelled delay.

Verification
REQ-030 in_data=128'h76abd7fe2b670130c56f6bf27b777c63 -> out_data=128'h0f0e0d0c0b0a09080706050403020100, out_valid 4 edges after accept (LANES=4).
REQ-031 in_data all bytes 8'h63 -> all bytes 8'h00; in_data all 8'h00 -> all 8'h52; in_data all 8'h16 -> all 8'hff.
REQ-032 Exhaustive round trip: for x=0..255, in_data = 16 copies of Sbox(x) -> every output byte = x; repeat with LANES=1 and LANES=16, checking latency 16 and 1.
REQ-033 Backpressure: out_ready held 0 for 10 cycles in DONE -> out_data constant, in_ready=0, a second in_valid pulse is ignored; on release, exactly one handshake occurs and the block returns to IDLE.
REQ-034 Reset during BUSY at cnt=2 -> out_valid=0, out_data=0, in_ready=1 after release; the next block (all bytes 8'h63) yields all bytes 8'h00.
